// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard between ID and EX: counts down producer latency and requests a stall
// while an ID source operand is still pending. Optional stall statistics under HAZARD_STATS_EN.
module hazard_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned LW   = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush_id,
  input  logic            flush_ex,
  input  logic            ID_valid,
  input  logic [AW-1:0]   ID_rs1,
  input  logic [AW-1:0]   ID_rs2,
  input  logic            ID_use_rs1,
  input  logic            ID_use_rs2,
  input  logic [AW-1:0]   ID_rd,
  input  logic [LW-1:0]   ID_lat,
  output logic            stall,
  output logic [NREG-1:0] busy_mask,
  output logic [15:0]     stall_count
);

  logic [LW-1:0]   cnt     [NREG];
  logic [LW-1:0]   cnt_nxt [NREG];
  logic [NREG-1:0] busy_nxt;
  logic [AW-1:0]   last_rd;
  logic            last_vld;
  logic [LW-1:0]   cnt_rs1, cnt_rs2;
  logic            working, hit1, hit2, issue;

  // Register 0 and indices >= NREG never match, so they read as idle.
  always_comb begin
    cnt_rs1 = '0;
    cnt_rs2 = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (ID_rs1 == AW'(r)) cnt_rs1 = cnt[r];
      if (ID_rs2 == AW'(r)) cnt_rs2 = cnt[r];
    end
  end

  assign working = !flush_id && !flush_ex;
  assign hit1    = ID_use_rs1 && (ID_rs1 != '0) && (cnt_rs1 != '0);
  assign hit2    = ID_use_rs2 && (ID_rs2 != '0) && (cnt_rs2 != '0);
  assign stall   = working && ID_valid && (hit1 || hit2);
  assign issue   = ID_valid && !stall && !flush_id && (ID_rd != '0) && (ID_lat != '0);

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) cnt_nxt[r] = '0;
    busy_nxt = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - LW'(1) : '0;
      if (flush_ex && last_vld && (last_rd == AW'(r))) cnt_nxt[r] = '0;
      // max(cnt-1 saturating, lat): ID_lat >= 1 on issue, so cnt > lat picks the decremented count.
      if (issue && (ID_rd == AW'(r)))
        cnt_nxt[r] = (cnt[r] > ID_lat) ? cnt[r] - LW'(1) : ID_lat;
      busy_nxt[r] = (cnt_nxt[r] != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '{default: '0};
      last_rd   <= '0;
      last_vld  <= 1'b0;
      busy_mask <= '0;
    end else begin
      cnt       <= cnt_nxt;
      last_rd   <= ID_rd;
      last_vld  <= issue;
      busy_mask <= busy_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST)
      stall_count <= '0;
    else if (stall && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned LW   = 3;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST, flush_id, flush_ex, ID_valid;
  logic [AW-1:0]   ID_rs1, ID_rs2, ID_rd;
  logic            ID_use_rs1, ID_use_rs2;
  logic [LW-1:0]   ID_lat;
  logic            stall;
  logic [NREG-1:0] busy_mask;
  logic [15:0]     stall_count;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .LW(LW)) dut (
    .CLK(CLK), .RST(RST), .flush_id(flush_id), .flush_ex(flush_ex),
    .ID_valid(ID_valid), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .ID_rd(ID_rd), .ID_lat(ID_lat),
    .stall(stall), .busy_mask(busy_mask), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic u1,
                       input logic [AW-1:0] rs2, input logic u2,
                       input logic [AW-1:0] rd, input logic [LW-1:0] lat);
    ID_valid = v; ID_rs1 = rs1; ID_use_rs1 = u1; ID_rs2 = rs2; ID_use_rs2 = u2;
    ID_rd = rd; ID_lat = lat;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; flush_id = 1'b0; flush_ex = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    RST = 1'b0;
    #1;
    check("rst_busy", 32'(busy_mask), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_count", 32'(stall_count), 32'h0);

    // Load-use: rd=5, lat=1
    drive(1, 0, 0, 0, 0, 5, 1);
    #1 check("lu_producer_nostall", 32'(stall), 32'h0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0);
    #1 check("lu_stall", 32'(stall), 32'h1);
    check("lu_busy", 32'(busy_mask), 32'h0000_0020);
    tick();
    check("lu_release", 32'(stall), 32'h0);
    check("lu_busy_clear", 32'(busy_mask), 32'h0);

    // Long latency: rd=7, lat=4, from a clean reset so stall_count is exactly 4
    drive(0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1; tick(); RST = 1'b0;
    drive(1, 0, 0, 0, 0, 7, 4);
    tick();
    drive(1, 0, 0, 7, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1 check("ll_stall", 32'(stall), 32'h1);
      check("ll_busy", 32'(busy_mask), 32'h0000_0080);
      tick();
    end
    check("ll_release", 32'(stall), 32'h0);
    check("ll_busy_clear", 32'(busy_mask), 32'h0);
    check("ll_count", 32'(stall_count), STATS ? 32'd4 : 32'd0);

    // Unused and zero operands with r3 pending
    drive(1, 0, 0, 0, 0, 3, 3);
    tick();
    drive(1, 0, 1, 3, 0, 0, 0);
    #1 check("unused_rs2_rs1_zero", 32'(stall), 32'h0);
    drive(1, 3, 1, 0, 0, 0, 0);
    #1 check("used_rs1_pending", 32'(stall), 32'h1);
    drive(0, 3, 1, 3, 1, 0, 0);
    #1 check("invalid_no_stall", 32'(stall), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    check("drain_r3", 32'(busy_mask), 32'h0);

    // WAW: rd=9 lat=5, then rd=9 lat=1 -> cnt 4
    drive(1, 0, 0, 0, 0, 9, 5);
    tick();
    drive(1, 0, 0, 0, 0, 9, 1);
    #1 check("waw_second_issue_nostall", 32'(stall), 32'h0);
    tick();
    drive(1, 9, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1 check("waw_stall", 32'(stall), 32'h1);
      tick();
    end
    check("waw_release", 32'(stall), 32'h0);
    check("waw_busy_clear", 32'(busy_mask), 32'h0);

    // Flush of the previously issued producer
    drive(1, 0, 0, 0, 0, 4, 3);
    tick();
    check("fl_busy_set", 32'(busy_mask), 32'h0000_0010);
    drive(0, 0, 0, 0, 0, 0, 0);
    flush_ex = 1'b1;
    tick();
    flush_ex = 1'b0;
    check("fl_busy_cleared", 32'(busy_mask), 32'h0);
    drive(1, 4, 1, 0, 0, 0, 0);
    #1 check("fl_consumer_nostall", 32'(stall), 32'h0);

    // flush_id masks stall
    drive(1, 0, 0, 0, 0, 4, 3);
    tick();
    drive(1, 4, 1, 0, 0, 0, 0);
    flush_id = 1'b1;
    #1 check("flush_id_nostall", 32'(stall), 32'h0);
    flush_id = 1'b0;
    #1 check("flush_id_released_stall", 32'(stall), 32'h1);

    // Reset mid-operation with r6 pending
    drive(1, 0, 0, 0, 0, 6, 3);
    tick();
    check("rm_busy6", 32'(busy_mask[6]), 32'h1);
    drive(1, 6, 1, 0, 0, 0, 0);
    #1 check("rm_stall_before", 32'(stall), 32'h1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rm_busy", 32'(busy_mask), 32'h0);
    check("rm_stall", 32'(stall), 32'h0);
    check("rm_count", 32'(stall_count), 32'h0);

    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use stall check. Sits between ID and EX.
- Tracks a per-register countdown of cycles until each pending destination result becomes forwardable. Generalises the fixed one-cycle load-use bubble to any producer latency (loads with multi-cycle memory, multiplier, divider).
- Asserts `stall` to hold the IF/ID stages while any source operand used by the ID instruction is still pending.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero and never tracked.
- AW, 5, register index width; must satisfy 2^AW >= NREG.
- LW, 3, latency field width; the maximum producer latency is 2^LW-1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- flush_id  input  1  the ID instruction is squashed this cycle.
- flush_ex  input  1  the instruction issued on the previous edge is squashed.
- ID_valid  input  1  the ID stage holds a real instruction.
- ID_rs1  input  AW  source register 1 index.
- ID_rs2  input  AW  source register 2 index.
- ID_use_rs1  input  1  the instruction reads rs1.
- ID_use_rs2  input  1  the instruction reads rs2 (R, B and S types).
- ID_rd  input  AW  destination index; 0 means no write.
- ID_lat  input  LW  stall cycles a consumer needs after issue (0 = ALU result forwardable, 1 = classic load).
- stall  output  1  combinational hold request.
- busy_mask  output  NREG  bit r = 1 while cnt[r] != 0; registered.
- stall_count  output  16  cumulative stall cycles (optional feature).

Behaviour:
- State: cnt[1..NREG-1], LW bits each; last_rd (AW bits) and last_vld (1 bit) record the most recent issue. Index 0 is constant 0.
- Reset (RST=1 at an edge):
  - all cnt = 0, last_vld = 0, stall_count = 0.
  - busy_mask = 0; stall = 0 from the first cycle after reset.
  - Reset mid-operation discards every pending entry.
- working = !flush_id & !flush_ex.
- hit1 = ID_use_rs1 & (ID_rs1 != 0) & (cnt[ID_rs1] != 0). hit2 is the same expression on rs2.
- stall = working & ID_valid & (hit1 | hit2). This is pure combinational logic on the current state; the ID instruction's own rd does not affect its own stall.
- issue = ID_valid & !stall & !flush_id & (ID_rd != 0) & (ID_lat != 0).
- Per-edge update, applied in this order:
  1. Decrement: every cnt != 0 decrements by 1, saturating at 0.
  2. Flush: if flush_ex & last_vld, cnt[last_rd] = 0, overriding the decrement.
  3. Issue: if issue, cnt[ID_rd] = max(decremented value, ID_lat). A write-after-write hazard keeps the later completion. Issue takes priority over the flush when both target the same register.
  4. Tracking: last_vld = issue and last_rd = ID_rd on every edge.
- Latency contract: a producer issued at edge E with ID_lat = L stalls a dependent consumer in ID during cycles E..E+L-1. The consumer proceeds in cycle E+L.
- Out-of-range indices (>= NREG) read as cnt = 0 and are never written.
- busy_mask reflects post-edge cnt values.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined: stall_count increments by 1 each cycle stall=1, saturates at 16'hFFFF, and clears on RST.
- When undefined: stall_count is tied to 16'h0000 and no counter flops are generated.

Test Plan:
- Load-use: issue rd=5, lat=1; next cycle ID rs1=5, use_rs1=1 -> stall=1 for exactly 1 cycle, then stall=0; busy_mask[5] is 1 for one cycle.
- Long latency: issue rd=7, lat=4; a consumer reading rs2=7 (use_rs2=1) follows immediately -> stall=1 for 4 consecutive cycles; stall_count=4 with HAZARD_STATS_EN.
- Unused and zero operands: cnt[3] pending; ID rs2=3 with use_rs2=0, or rs1=0 -> stall=0.
- WAW: issue rd=9, lat=5; the next cycle issue rd=9, lat=1 -> cnt[9] = 4 (max rule); the consumer stalls 4 cycles.
- Flush: issue rd=4, lat=3; the next cycle assert flush_ex -> cnt[4]=0 and busy_mask[4]=0; a later consumer of r4 sees stall=0. Also, flush_id=1 forces stall=0 regardless of pending entries.
- Reset mid-operation: cnt[6]=3; assert RST for 1 cycle -> busy_mask=0, stall=0, stall_count=0.
